// File: rtl/multi_inst_rob.sv
// Multi-issue reorder buffer: in-order allocation of up to DP_WIDTH entries per cycle,
// out-of-order completion, in-order retirement of up to COM_WIDTH entries, and branch squash.
module multi_inst_rob #(
  parameter  int ROB_DEPTH = 64,
  parameter  int DP_WIDTH  = 2,
  parameter  int COM_WIDTH = 2,
  parameter  int FIN_PORTS = 4,
  parameter  int REG_SEL   = 5,
  parameter  int ADDR_LEN  = 32,
  localparam int TAG_W     = $clog2(ROB_DEPTH),
  localparam int CNT_W     = $clog2(COM_WIDTH) + 1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [DP_WIDTH-1:0]           dp_valid_i,
  input  logic [DP_WIDTH*ADDR_LEN-1:0]  dp_pc_i,
  input  logic [DP_WIDTH-1:0]           dp_dst_valid_i,
  input  logic [DP_WIDTH*REG_SEL-1:0]   dp_dst_i,
  output logic                          dp_ready_o,
  output logic [DP_WIDTH*TAG_W-1:0]     dp_tag_o,
  input  logic [FIN_PORTS-1:0]          fin_valid_i,
  input  logic [FIN_PORTS*TAG_W-1:0]    fin_tag_i,
  input  logic                          flush_i,
  input  logic [TAG_W-1:0]              flush_tag_i,
  output logic [COM_WIDTH-1:0]          commit_valid_o,
  output logic [COM_WIDTH*TAG_W-1:0]    commit_tag_o,
  output logic [COM_WIDTH-1:0]          commit_arfwe_o,
  output logic [COM_WIDTH*REG_SEL-1:0]  commit_dst_o,
  output logic [COM_WIDTH*ADDR_LEN-1:0] commit_pc_o,
  output logic [CNT_W-1:0]              comnum_o,
  output logic [TAG_W:0]                count_o,
  output logic                          empty_o
);

  localparam logic [TAG_W:0] DEPTH_P = (TAG_W+1)'(ROB_DEPTH);
  localparam logic [TAG_W:0] DPW_P   = (TAG_W+1)'(DP_WIDTH);

  logic [TAG_W:0]         r_head, r_tail;
  logic [ROB_DEPTH-1:0]   r_valid, r_fin, r_dstv;
  logic [REG_SEL-1:0]     r_dst [ROB_DEPTH];
  logic [ADDR_LEN-1:0]    r_pc  [ROB_DEPTH];

  logic [TAG_W:0]         w_count;
  logic                   w_ready;
  logic                   w_flush;
  logic [TAG_W-1:0]       w_flush_rel;
  logic [DP_WIDTH-1:0]    w_dp_acc;
  logic [TAG_W:0]         w_dp_num;
  logic                   w_dp_run;
  logic                   w_cm_run;
  logic [TAG_W-1:0]       w_cm_idx;

  // Dispatch side: everything visible here comes from registered pointers only.
  always_comb begin
    w_count     = r_tail - r_head;
    w_ready     = (DEPTH_P - w_count) >= DPW_P;
    w_flush     = flush_i & r_valid[flush_tag_i];
    w_flush_rel = flush_tag_i - r_head[TAG_W-1:0];
    w_dp_acc    = '0;
    w_dp_num    = '0;
    w_dp_run    = w_ready & ~w_flush;
    dp_tag_o    = '0;
    for (int unsigned k = 0; k < DP_WIDTH; k++) begin
      dp_tag_o[k*TAG_W +: TAG_W] = r_tail[TAG_W-1:0] + TAG_W'(k);
      if (w_dp_run && dp_valid_i[k]) begin
        w_dp_acc[k] = 1'b1;
        w_dp_num    = w_dp_num + (TAG_W+1)'(1);
      end else begin
        w_dp_run = 1'b0;
      end
    end
  end

  always_comb begin
    w_cm_run       = 1'b1;
    w_cm_idx       = '0;
    comnum_o       = '0;
    commit_valid_o = '0;
    commit_arfwe_o = '0;
    commit_tag_o   = '0;
    commit_dst_o   = '0;
    commit_pc_o    = '0;
    for (int unsigned k = 0; k < COM_WIDTH; k++) begin
      w_cm_idx = r_head[TAG_W-1:0] + TAG_W'(k);
      w_cm_run = w_cm_run && ((TAG_W+1)'(k) < w_count) && r_valid[w_cm_idx] && r_fin[w_cm_idx];
      commit_valid_o[k]                    = w_cm_run;
      commit_arfwe_o[k]                    = w_cm_run & r_dstv[w_cm_idx];
      commit_tag_o[k*TAG_W +: TAG_W]       = w_cm_idx;
      commit_dst_o[k*REG_SEL +: REG_SEL]   = r_dst[w_cm_idx];
      commit_pc_o[k*ADDR_LEN +: ADDR_LEN]  = r_pc[w_cm_idx];
      if (w_cm_run) comnum_o = comnum_o + CNT_W'(1);
    end
  end

  assign dp_ready_o = w_ready;
  assign count_o    = w_count;
  assign empty_o    = (w_count == '0);

  // Later assignments override earlier ones: finish < commit clear < squash < allocate.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_fin   <= '0;
    end else begin
      for (int unsigned p = 0; p < FIN_PORTS; p++) begin
        if (fin_valid_i[p] && r_valid[fin_tag_i[p*TAG_W +: TAG_W]])
          r_fin[fin_tag_i[p*TAG_W +: TAG_W]] <= 1'b1;
      end
      for (int unsigned k = 0; k < COM_WIDTH; k++) begin
        if (commit_valid_o[k]) begin
          r_valid[r_head[TAG_W-1:0] + TAG_W'(k)] <= 1'b0;
          r_fin[r_head[TAG_W-1:0] + TAG_W'(k)]   <= 1'b0;
        end
      end
      if (w_flush) begin
        for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
          if ((TAG_W'(i) - r_head[TAG_W-1:0]) > w_flush_rel) begin
            r_valid[i] <= 1'b0;
            r_fin[i]   <= 1'b0;
          end
        end
      end
      for (int unsigned k = 0; k < DP_WIDTH; k++) begin
        if (w_dp_acc[k]) begin
          r_valid[r_tail[TAG_W-1:0] + TAG_W'(k)] <= 1'b1;
          r_fin[r_tail[TAG_W-1:0] + TAG_W'(k)]   <= 1'b0;
        end
      end
      r_head <= r_head + (TAG_W+1)'(comnum_o);
      // Rebuilding the tail from the head keeps the wrap bit consistent with count <= depth.
      r_tail <= w_flush ? (r_head + {1'b0, w_flush_rel} + (TAG_W+1)'(1)) : (r_tail + w_dp_num);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < DP_WIDTH; k++) begin
      if (w_dp_acc[k]) begin
        r_dstv[r_tail[TAG_W-1:0] + TAG_W'(k)] <= dp_dst_valid_i[k];
        r_dst[r_tail[TAG_W-1:0] + TAG_W'(k)]  <= dp_dst_i[k*REG_SEL +: REG_SEL];
        r_pc[r_tail[TAG_W-1:0] + TAG_W'(k)]   <= dp_pc_i[k*ADDR_LEN +: ADDR_LEN];
      end
    end
  end

endmodule

// File: tb/tb_multi_inst_rob.sv
// Bench for multi_inst_rob (depth 8): directed scenarios then random traffic, all checked
// against an in-order queue model of the ROB contents.
module tb_multi_inst_rob;
  localparam int D  = 8;
  localparam int TW = 3;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic [1:0]  dp_valid_i;
  logic [63:0] dp_pc_i;
  logic [1:0]  dp_dst_valid_i;
  logic [9:0]  dp_dst_i;
  logic        dp_ready_o;
  logic [5:0]  dp_tag_o;
  logic [3:0]  fin_valid_i;
  logic [11:0] fin_tag_i;
  logic        flush_i;
  logic [2:0]  flush_tag_i;
  logic [1:0]  commit_valid_o;
  logic [5:0]  commit_tag_o;
  logic [1:0]  commit_arfwe_o;
  logic [9:0]  commit_dst_o;
  logic [63:0] commit_pc_o;
  logic [1:0]  comnum_o;
  logic [3:0]  count_o;
  logic        empty_o;

  multi_inst_rob #(.ROB_DEPTH(D), .DP_WIDTH(2), .COM_WIDTH(2), .FIN_PORTS(4),
                   .REG_SEL(5), .ADDR_LEN(32)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .dp_valid_i(dp_valid_i), .dp_pc_i(dp_pc_i), .dp_dst_valid_i(dp_dst_valid_i),
    .dp_dst_i(dp_dst_i), .dp_ready_o(dp_ready_o), .dp_tag_o(dp_tag_o),
    .fin_valid_i(fin_valid_i), .fin_tag_i(fin_tag_i),
    .flush_i(flush_i), .flush_tag_i(flush_tag_i),
    .commit_valid_o(commit_valid_o), .commit_tag_o(commit_tag_o),
    .commit_arfwe_o(commit_arfwe_o), .commit_dst_o(commit_dst_o),
    .commit_pc_o(commit_pc_o), .comnum_o(comnum_o), .count_o(count_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    bit         fin;
    bit         dv;
    bit [4:0]   dst;
    bit [31:0]  pc;
  } ent_t;

  ent_t q[$];
  int   nt;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cn();
    int n = 0;
    while (n < 2 && n < q.size() && q[n].fin) n++;
    return n;
  endfunction

  task automatic check_outputs();
    int cn;
    logic [5:0]  etag, atag, edtag;
    logic [9:0]  edst, adst;
    logic [63:0] epc, apc;
    logic [1:0]  ecv, ewe;
    cn = exp_cn();
    etag = '0; atag = '0; edst = '0; adst = '0; epc = '0; apc = '0; ecv = '0; ewe = '0;
    for (int k = 0; k < 2; k++) begin
      edtag[k*3 +: 3] = 3'((nt + k) % D);
      if (k < cn) begin
        ecv[k]            = 1'b1;
        ewe[k]            = q[k].dv;
        etag[k*3 +: 3]    = 3'(q[k].tag);
        edst[k*5 +: 5]    = q[k].dst;
        epc[k*32 +: 32]   = q[k].pc;
        atag[k*3 +: 3]    = commit_tag_o[k*3 +: 3];
        adst[k*5 +: 5]    = commit_dst_o[k*5 +: 5];
        apc[k*32 +: 32]   = commit_pc_o[k*32 +: 32];
      end
    end
    chk("count",        64'(count_o),        64'(q.size()));
    chk("empty",        64'(empty_o),        64'(q.size() == 0));
    chk("dp_ready",     64'(dp_ready_o),     64'((D - q.size()) >= 2));
    chk("dp_tag",       64'(dp_tag_o),       64'(edtag));
    chk("commit_valid", 64'(commit_valid_o), 64'(ecv));
    chk("comnum",       64'(comnum_o),       64'(cn));
    chk("commit_arfwe", 64'(commit_arfwe_o), 64'(ewe));
    if (cn > 0) begin
      chk("commit_tag", 64'(atag), 64'(etag));
      chk("commit_dst", 64'(adst), 64'(edst));
      chk("commit_pc",  apc,       epc);
    end
  endtask

  task automatic model_update();
    int  cn, fi;
    bit  rdy;
    ent_t e;
    cn  = exp_cn();
    rdy = (D - q.size()) >= 2;
    fi  = -1;
    if (flush_i)
      for (int i = 0; i < q.size(); i++) if (q[i].tag == int'(flush_tag_i)) fi = i;
    for (int p = 0; p < 4; p++)
      if (fin_valid_i[p])
        for (int i = 0; i < q.size(); i++)
          if (q[i].tag == int'(fin_tag_i[p*3 +: 3])) q[i].fin = 1'b1;
    if (fi >= 0) begin
      while (q.size() > fi + 1) void'(q.pop_back());
      nt = (int'(flush_tag_i) + 1) % D;
    end
    repeat (cn) void'(q.pop_front());
    if (fi < 0 && rdy) begin
      for (int k = 0; k < 2; k++) begin
        if (!dp_valid_i[k]) break;
        e.tag = nt; e.fin = 1'b0; e.dv = dp_dst_valid_i[k];
        e.dst = dp_dst_i[k*5 +: 5]; e.pc = dp_pc_i[k*32 +: 32];
        q.push_back(e);
        nt = (nt + 1) % D;
      end
    end
  endtask

  task automatic idle();
    dp_valid_i     = '0;
    fin_valid_i    = '0;
    fin_tag_i      = '0;
    flush_i        = 1'b0;
    flush_tag_i    = '0;
    dp_pc_i        = {$urandom, $urandom};
    dp_dst_i       = 10'($urandom);
    dp_dst_valid_i = 2'($urandom);
  endtask

  // Check current outputs, take one clock edge, advance the model, return inputs to idle.
  task automatic cyc();
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
    idle();
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    #2;
    q.delete();
    nt = 0;
    check_outputs();
    reset_n_i = 1'b1;
  endtask

  initial begin
    reset_n_i = 1'b0;
    idle();
    q.delete();
    nt = 0;
    #1 check_outputs();
    #11 reset_n_i = 1'b1;

    // Reset mid-run with 5 entries in flight
    dp_valid_i = 2'b11; cyc();
    dp_valid_i = 2'b11; cyc();
    dp_valid_i = 2'b01; cyc();
    chk("inflight_count", 64'(count_o), 64'd5);
    do_reset();

    // Fill to depth, then an ignored request
    repeat (4) begin dp_valid_i = 2'b11; cyc(); end
    dp_valid_i = 2'b11; cyc();
    cyc();

    // Out-of-order finish, in-order retire
    fin_valid_i = 4'b0001; fin_tag_i = 12'd3; cyc();
    fin_valid_i = 4'b0001; fin_tag_i = 12'd2; cyc();
    fin_valid_i = 4'b0001; fin_tag_i = 12'd1; cyc();
    fin_valid_i = 4'b0001; fin_tag_i = 12'd0; cyc();
    cyc();
    cyc();

    // Retire 4,5 then dispatch across the wrap
    fin_valid_i = 4'b0011; fin_tag_i = {3'd0, 3'd0, 3'd5, 3'd4}; cyc();
    cyc();
    dp_valid_i = 2'b11; cyc();
    dp_valid_i = 2'b11; cyc();
    cyc();

    // Flush with concurrent dispatch, then stale finish on a squashed tag
    do_reset();
    repeat (3) begin dp_valid_i = 2'b11; cyc(); end
    flush_i = 1'b1; flush_tag_i = 3'd2; dp_valid_i = 2'b11; cyc();
    fin_valid_i = 4'b0001; fin_tag_i = 12'd4; cyc();
    dp_valid_i = 2'b11; cyc();
    fin_valid_i = 4'b1111; fin_tag_i = {3'd3, 3'd2, 3'd1, 3'd0}; cyc();
    repeat (3) cyc();

    // Finish and dispatch in the same cycle, gap in dispatch request
    do_reset();
    dp_valid_i = 2'b01; cyc();
    fin_valid_i = 4'b0001; fin_tag_i = 12'd0; dp_valid_i = 2'b11; cyc();
    dp_valid_i = 2'b10; cyc();
    cyc();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      dp_valid_i  = 2'($urandom);
      fin_valid_i = 4'($urandom) & 4'($urandom);
      fin_tag_i   = 12'($urandom);
      flush_i     = ($urandom_range(0, 11) == 0);
      flush_tag_i = 3'($urandom);
      if ($urandom_range(0, 149) == 0) do_reset();
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multi_inst_rob.md
# multi_inst_rob

Parametrised reorder buffer for the HeliosX out-of-order core, replacing the single-instruction ROB. It allocates up to `DP_WIDTH` entries per cycle in program order and accepts out-of-order completion on `FIN_PORTS` execution ports. It retires up to `COM_WIDTH` oldest contiguous finished entries per cycle to the ARF/rename logic. It adds mispredict squash of all entries younger than a branch tag.

## Interface
- `ROB_DEPTH`, 64: entry count; power of two, at least 4 and at least `DP_WIDTH`.
- `DP_WIDTH`, 2: dispatch ports.
- `COM_WIDTH`, 2: commit ports.
- `FIN_PORTS`, 4: completion ports (ALU, branch, mul, ldst).
- `REG_SEL`, 5: architectural register index width.
- `ADDR_LEN`, 32: PC width.
- `TAG_W` is derived as log2(`ROB_DEPTH`). All per-port vectors are packed with port 0 in the LSBs.

Ports:
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `dp_valid_i`  in  `DP_WIDTH`  dispatch request per port.
- `dp_pc_i`  in  `DP_WIDTH*ADDR_LEN`  instruction PC.
- `dp_dst_valid_i`  in  `DP_WIDTH`  instruction writes rd.
- `dp_dst_i`  in  `DP_WIDTH*REG_SEL`  rd index.
- `dp_ready_o`  out  1  at least `DP_WIDTH` entries free.
- `dp_tag_o`  out  `DP_WIDTH*TAG_W`  tag assigned to each port this cycle.
- `fin_valid_i`  in  `FIN_PORTS`  completion strobe.
- `fin_tag_i`  in  `FIN_PORTS*TAG_W`  completing entry.
- `flush_i`  in  1  branch mispredict.
- `flush_tag_i`  in  `TAG_W`  mispredicted branch's tag.
- `commit_valid_o`  out  `COM_WIDTH`  retiring slot k.
- `commit_tag_o`  out  `COM_WIDTH*TAG_W`  tag retiring on slot k (also the RRF index).
- `commit_arfwe_o`  out  `COM_WIDTH`  ARF write enable.
- `commit_dst_o`  out  `COM_WIDTH*REG_SEL`  ARF destination.
- `commit_pc_o`  out  `COM_WIDTH*ADDR_LEN`  retiring PC.
- `comnum_o`  out  log2(`COM_WIDTH`)+1  number retiring this cycle.
- `count_o`  out  `TAG_W`+1  occupied entries.
- `empty_o`  out  1  `count_o`==0.

## Operation
- **Storage.** Per entry: valid, finished, dst_valid, dst, pc.
- **Pointers.** Head and tail are `TAG_W`+1 bits; the MSB is the wrap bit. Count = tail − head, modulo 2^(`TAG_W`+1). Full when count == `ROB_DEPTH`.
- **Dispatch.**
  - `dp_ready_o` = (`ROB_DEPTH` − count ≥ `DP_WIDTH`), using registered count only.
  - `dp_tag_o[k]` = tail+k (low `TAG_W` bits), driven combinationally every cycle.
  - When `dp_ready_o` is high, the accepted ports are the longest prefix of set `dp_valid_i` bits. A gap ends acceptance: for `dp_valid_i`=2'b10, nothing is accepted.
  - Each accepted entry is written valid=1, finished=0. Tail advances by the accepted count.
  - While `dp_ready_o` is low, requests are ignored.
- **Finish.** Each `fin_valid_i` port sets finished on its tag if that entry is valid; otherwise it is ignored. Duplicate tags across ports are legal.
- **Commit.**
  - Slot k is valid iff entries head..head+k are all valid and finished (registered state), and k < count.
  - Slots retire as a contiguous prefix; `comnum_o` = number of valid slots.
  - At the edge, retired entries are cleared and head advances by `comnum_o`.
  - `commit_arfwe_o[k]` = `commit_valid_o[k]` & dst_valid.
- **Flush.**
  - Applies only if entry `flush_tag_i` is valid.
  - All entries strictly younger than the flush tag (flush_tag+1 .. tail−1) are cleared. Tail becomes flush_tag+1, with the wrap bit chosen so that count stays at most `ROB_DEPTH`.
  - The branch entry itself survives.
- **Simultaneous events.**
  - Flush and dispatch in the same cycle: flush wins; dispatch is dropped and the tags shown are not allocated.
  - Flush and commit in the same cycle: commit proceeds, since committed entries are never younger than a valid flush tag. Head and tail updates are both applied.
  - Finish and commit of the same entry in the same cycle: the entry commits the following cycle.
  - Finish to an entry being flushed this cycle: flush wins.
  - Dispatch and commit in the same cycle: both apply. Freed slots are visible to `dp_ready_o` next cycle.
- **Reset (async, low).**
  - Head and tail = 0; all valid and finished bits = 0.
  - `dp_ready_o`=1, `dp_tag_o`={k}, `commit_valid_o`=0, `commit_arfwe_o`=0, `comnum_o`=0, `count_o`=0, `empty_o`=1.
  - Reset asserted mid-operation discards all in-flight entries immediately.

## Timing
- Dispatch is sampled at edge t. The earliest finish of that entry is sampled at edge t+1.
- Commit outputs assert combinationally in the cycle after the finish edge, and head advances at the next edge. Minimum dispatch-to-retire latency is 2 edges.
- `dp_ready_o`, `count_o`, `empty_o`, and `dp_tag_o` are functions of registered pointers only, with no input-to-output combinational path.
- Commit outputs depend only on registered state.

## Test plan
- **Reset.** Hold `reset_n_i`=0 mid-run with 5 entries in flight, then release → `count_o`=0, `empty_o`=1, `dp_tag_o`={0,1}, no `commit_valid_o`.
- **Fill.** `ROB_DEPTH`=8; dispatch 2/cycle for 4 cycles with no finishes → tags 0..7, `count_o`=8, `dp_ready_o`=0. A fifth request is ignored and the tail is unchanged.
- **Out-of-order finish.** Finish tags 3, 2, 1 on separate cycles → no commit. Finish tag 0 → cycle 1: commit tags 0,1 (`comnum_o`=2); next cycle: tags 2,3.
- **Wrap-around.** Depth 8; retire 6, then dispatch 4 → tags 0,1 reused; `count_o` correct across the wrap bit.
- **Flush.** Entries 0..5, `flush_tag_i`=2, with `dp_valid_i`=2'b11 in the same cycle → `count_o`=3, next `dp_tag_o`={3,4}. A later finish on tag 4 has no effect until 4 is re-dispatched.
- **Same-cycle finish/commit and dispatch.** Finish tag 0 and dispatch 2 in the same cycle → tag 0 commits the next cycle with `commit_arfwe_o` matching its dst_valid; `count_o` +2, then −1.
